// File: rtl/scaler_v.sv
// Vertical bilinear down-scaler: blends the buffered previous line with the incoming line.
// Latency: fixed 3 clk from de_i/hs_i/vs_i to de_o/hs_o/vs_o.
// Backpressure: none; the input stream is accepted at line rate and gaps pass through 1:1.
//
// Ports: clk/rst (sync, active-high); scale_step = input lines per output line (4.12);
//        di_i/de_i/hs_i/vs_i = input pixel stream; do_o/de_o/hs_o/vs_o = output stream.
// Build option: define SCALER_V_ROUND_EN to round the blend half-up instead of truncating.
module scaler_v #(
    parameter int LINE_SIZE_MAX  = 4096,
    parameter int DATA_WIDTH     = 8,
    parameter int PIXEL_STEP     = 4096,
    parameter int LINE_CNT_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           scale_step,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o
);
    localparam int AW   = $clog2(LINE_SIZE_MAX);
    localparam int XW   = AW + 1;                 // one extra bit so x can exceed the buffer
    localparam int PAW  = LINE_CNT_WIDTH + 12;    // position accumulator, 12 fraction bits
    localparam int PW   = DATA_WIDTH + 13;        // partial product width
    localparam int ACCW = DATA_WIDTH + 14;        // blend sum width

    typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_LINE, S_HBLANK} state_t;

    state_t                    state_q, state_n;
    logic [LINE_CNT_WIDTH-1:0] n_q;
    logic [PAW-1:0]            p_q;
    logic [15:0]               step_q;
    logic [XW-1:0]             x_q;

    logic                      emit_hit;
    logic                      accept;
    logic                      in_range;
    logic [AW-1:0]             addr;

    logic [DATA_WIDTH-1:0]     line_buf [LINE_SIZE_MAX];
    logic [DATA_WIDTH-1:0]     ram_rd;

    logic                      s1_de, s1_hs, s1_vs;
    logic [DATA_WIDTH-1:0]     s1_cur;
    logic [11:0]               s1_f;
    logic [12:0]               w_prev;
    logic                      s2_de, s2_hs, s2_vs;
    logic [PW-1:0]             s2_a, s2_b;
    logic [ACCW-1:0]           acc_sum;

    // Current input line n is an output line when the integer part of the
    // source position sits exactly one line behind it (prev = line int(p)).
    assign emit_hit = (p_q[PAW-1:12] + LINE_CNT_WIDTH'(1)) == n_q;
    assign accept   = de_i && !hs_i && !vs_i && (state_q != S_SYNC);
    assign in_range = x_q < XW'(LINE_SIZE_MAX);
    assign addr     = x_q[AW-1:0];
    assign w_prev   = 13'd4096 - {1'b0, s1_f};

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_SYNC:   if (vs_i) state_n = S_VBLANK;
            S_VBLANK: if (!vs_i && !hs_i) state_n = S_LINE;
            S_LINE:   if (hs_i || vs_i) state_n = S_HBLANK;
            S_HBLANK: begin
                if (vs_i)       state_n = S_VBLANK;
                else if (!hs_i) state_n = S_LINE;
            end
            default:  state_n = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
            n_q     <= '0;
            p_q     <= '0;
            step_q  <= 16'(PIXEL_STEP);
        end else begin
            state_q <= state_n;
            if (state_q == S_VBLANK) begin
                n_q    <= '0;
                p_q    <= '0;
                // Steps below 1.0 would upscale; clamp so each input line yields at most one output.
                step_q <= (scale_step < 16'(PIXEL_STEP)) ? 16'(PIXEL_STEP) : scale_step;
            end else if (state_q == S_LINE && state_n == S_HBLANK) begin
                n_q <= n_q + LINE_CNT_WIDTH'(1);
                if (emit_hit) p_q <= p_q + PAW'(step_q);
            end
        end
    end

    // Saturating pixel counter so over-long lines never alias back into the buffer.
    always_ff @(posedge clk) begin
        if (rst || hs_i)                  x_q <= '0;
        else if (de_i && (x_q != '1))     x_q <= x_q + XW'(1);
    end

    // Line buffer: read returns the previous line's pixel before it is overwritten.
    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && in_range) line_buf[addr] <= di_i;
        ram_rd <= line_buf[addr];
    end

    always_comb begin
        acc_sum = ACCW'(s2_a) + ACCW'(s2_b);
`ifdef SCALER_V_ROUND_EN
        acc_sum = acc_sum + ACCW'(2048);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_de  <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_cur <= '0;
            s1_f   <= '0;
            s2_de  <= 1'b0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_a   <= '0;
            s2_b   <= '0;
            do_o   <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b1;
            vs_o   <= 1'b1;
        end else begin
            // Stage 1: RAM read in flight, capture current pixel and blend weight.
            s1_de  <= accept && in_range && emit_hit;
            s1_hs  <= hs_i;
            s1_vs  <= vs_i;
            s1_cur <= di_i;
            s1_f   <= p_q[11:0];
            // Stage 2: weighted products (weights sum to 4096, so no overflow).
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_a   <= PW'(ram_rd) * PW'(w_prev);
            s2_b   <= PW'(s1_cur) * PW'(s1_f);
            // Stage 3: sum and drop the 12 fraction bits.
            de_o   <= s2_de;
            hs_o   <= s2_hs;
            vs_o   <= s2_vs;
            do_o   <= s2_de ? DATA_WIDTH'(acc_sum >> 12) : '0;
        end
    end
endmodule
